// File: rtl/dma_io_channel.sv
`default_nettype none
// ============================================================================
//  Module   : dma_io_channel
//  Purpose  : Single-channel DMA engine that drains IO device 1 into main
//             memory. On a device request it obtains the bus from the CPU
//             (hold_req/hold_ack), then copies COUNT words from device buffer
//             index SRC.. to memory address DST.., two cycles per word, and
//             finishes with a one-cycle done_irq pulse.
//  Ports    : clk/reset             - clock, synchronous active-high reset
//             cfg_we/addr/wdata     - CPU register writes (0=SRC 1=DST 2=COUNT)
//             cfg_rdata             - combinational register readback (3=STATUS)
//             dreq/dack             - device request / acknowledge
//             hold_req/hold_ack     - bus request / grant handshake with CPU
//             io_index/io_write/io_rdata - device buffer read port
//             mem_addr/wdata/we     - memory write port
//             busy/done_irq         - channel activity / completion pulse
//  Options  : DMA_AUTOINIT_EN - keep shadow copies of SRC/DST/COUNT and
//             reload the working registers on completion.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_io_channel #(
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   input  logic              dreq,
   output logic              dack,
   output logic              hold_req,
   input  logic              hold_ack,
   output logic [8:0]        io_index,
   output logic              io_write,
   input  logic [31:0]       io_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done_irq
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [7:0]        src_q,   src_d;
   logic [ADDR_W-1:0] dst_q,   dst_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [31:0]       data_q,  data_d;
   logic              done_q,  done_d;
   logic              w_cfg_ok;

   // Only the low bits of the write data land in registers.
   logic w_unused_wdata;
   assign w_unused_wdata = &{1'b0, cfg_wdata};

   // Registers are only reprogrammable while the channel is idle.
   assign w_cfg_ok = cfg_we && (state_q == S_IDLE);

`ifdef DMA_AUTOINIT_EN
   logic [7:0]        src_sh_q, src_sh_d;
   logic [ADDR_W-1:0] dst_sh_q, dst_sh_d;
   logic [CNT_W-1:0]  cnt_sh_q, cnt_sh_d;

   always_comb begin
      src_sh_d = src_sh_q;
      dst_sh_d = dst_sh_q;
      cnt_sh_d = cnt_sh_q;
      if (w_cfg_ok) begin
         case (cfg_addr)
            2'd0:    src_sh_d = cfg_wdata[7:0];
            2'd1:    dst_sh_d = cfg_wdata[ADDR_W-1:0];
            2'd2:    cnt_sh_d = cfg_wdata[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_sh_q <= '0;
         dst_sh_q <= '0;
         cnt_sh_q <= '0;
      end else begin
         src_sh_q <= src_sh_d;
         dst_sh_q <= dst_sh_d;
         cnt_sh_q <= cnt_sh_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      done_d  = done_q;

      // Any CPU write clears the sticky done flag, even while busy.
      if (cfg_we) done_d = 1'b0;

      if (w_cfg_ok) begin
         case (cfg_addr)
            2'd0:    src_d = cfg_wdata[7:0];
            2'd1:    dst_d = cfg_wdata[ADDR_W-1:0];
            2'd2:    cnt_d = cfg_wdata[CNT_W-1:0];
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            // A request with nothing programmed is silently dropped.
            if (dreq && (cnt_q != '0)) state_d = S_REQ;
         end
         S_REQ: begin
            if (hold_ack) state_d = S_READ;
         end
         S_READ: begin
            data_d  = io_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            src_d = src_q + 8'd1;
            dst_d = dst_q + ADDR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
            // Grant loss is only honoured between words, so the word in
            // flight always completes before the channel pauses.
            if (cnt_q == CNT_W'(1))  state_d = S_DONE;
            else if (!hold_ack)      state_d = S_REQ;
            else                     state_d = S_READ;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef DMA_AUTOINIT_EN
            src_d = src_sh_q;
            dst_d = dst_sh_q;
            cnt_d = cnt_sh_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   // Bus is kept requested across READ/WRITE so the grant is not bounced
   // between consecutive words.
   assign hold_req  = (state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE);
   assign dack      = (state_q == S_READ);
   assign io_index  = (state_q == S_READ) ? {1'b1, src_q} : 9'd0;
   assign io_write  = 1'b0;
   assign mem_we    = (state_q == S_WRITE);
   assign mem_addr  = (state_q == S_WRITE) ? dst_q  : '0;
   assign mem_wdata = (state_q == S_WRITE) ? data_q : '0;
   assign busy      = (state_q != S_IDLE);
   assign done_irq  = (state_q == S_DONE);

   always_comb begin
      cfg_rdata = 32'd0;
      case (cfg_addr)
         2'd0:    cfg_rdata = {24'd0, src_q};
         2'd1:    cfg_rdata = {{(32-ADDR_W){1'b0}}, dst_q};
         2'd2:    cfg_rdata = {{(32-CNT_W){1'b0}}, cnt_q};
         default: cfg_rdata = {29'd0, dreq, done_q, busy};
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_io_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_io_channel
//  Purpose  : Self-checking bench for dma_io_channel. A device buffer model
//             feeds io_rdata, a CPU model grants the bus with optional
//             stalls, and every block transfer is compared against a list of
//             (address, data, index) triples computed from the programmed
//             SRC/DST/COUNT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_io_channel;
   localparam int ADDR_W = 13;
   localparam int CNT_W  = 9;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [1:0]        cfg_addr;
   logic [31:0]       cfg_wdata;
   logic [31:0]       cfg_rdata;
   logic              dreq;
   logic              dack;
   logic              hold_req;
   logic              hold_ack;
   logic [8:0]        io_index;
   logic              io_write;
   logic [31:0]       io_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              busy;
   logic              done_irq;

   always #5 clk = ~clk;

   dma_io_channel #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .dreq(dreq), .dack(dack), .hold_req(hold_req), .hold_ack(hold_ack),
      .io_index(io_index), .io_write(io_write), .io_rdata(io_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .busy(busy), .done_irq(done_irq)
   );

   // Device buffer: combinational read by index.
   logic [31:0] dev_buf [256];
   assign io_rdata = dev_buf[io_index[7:0]];

   int tests_run    = 0;
   int tests_failed = 0;

   // Observation records, written only by the monitor.
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [31:0]       wr_data_q [$];
   logic [8:0]        idx_q     [$];
   int   irq_cnt      = 0;
   int   irq_wide     = 0;
   int   hreq_cycles  = 0;
   int   pause_cycles = 0;
   logic irq_prev     = 1'b0;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (dack) idx_q.push_back(io_index);
      if (done_irq) irq_cnt++;
      if (done_irq && irq_prev) irq_wide++;
      irq_prev = done_irq;
      if (hold_req) hreq_cycles++;
      if (hold_req && !dack && !mem_we) pause_cycles++;
   end

   // CPU bus-grant model: grants one cycle after the request, can be forced
   // low or stalled at random.
   logic force_low  = 1'b0;
   logic rand_stall = 1'b0;
   initial begin : g_grant
      int   stall_left;
      logic prev_req;
      stall_left = 0;
      prev_req   = 1'b0;
      hold_ack   = 1'b0;
      forever begin
         @(negedge clk);
         if (stall_left > 0) begin
            stall_left--;
            hold_ack = 1'b0;
         end else if (force_low) begin
            hold_ack = 1'b0;
         end else if (rand_stall && hold_ack && ($urandom_range(0, 5) == 0)) begin
            stall_left = int'($urandom_range(1, 4));
            hold_ack   = 1'b0;
         end else begin
            hold_ack = prev_req;
         end
         prev_req = hold_req;
      end
   end

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0; cfg_wdata = 32'd0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      cfg_addr = a;
      #1 d = cfg_rdata;
   endtask

   task automatic program_regs(input logic [7:0] s, input logic [ADDR_W-1:0] d,
                               input logic [CNT_W-1:0] n);
      cfg_write(2'd0, {24'd0, s});
      cfg_write(2'd1, 32'(d));
      cfg_write(2'd2, 32'(n));
   endtask

   // Runs one programmed block to completion and checks everything observable.
   task automatic run_block(input logic [7:0] s, input logic [ADDR_W-1:0] d,
                            input logic [CNT_W-1:0] n, input string tag);
      int base_w, base_i, base_irq, base_wide, got_n;
      bit got;
      logic [31:0] rd;
      logic [7:0]        si;
      logic [ADDR_W-1:0] ea;
      logic [7:0]        exp_src;
      logic [ADDR_W-1:0] exp_dst;
      logic [CNT_W-1:0]  exp_cnt;
      base_w    = wr_addr_q.size();
      base_i    = idx_q.size();
      base_irq  = irq_cnt;
      base_wide = irq_wide;
      got = 1'b0;
      dreq = 1'b1;
      for (int c = 0; c < int'(n) * 16 + 100; c++) begin
         @(negedge clk);
         if (done_irq) begin got = 1'b1; break; end
      end
      dreq = 1'b0;
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL %s_done_timeout: got no done_irq, want a pulse", tag);
      end
      repeat (2) @(negedge clk);

      got_n = wr_addr_q.size() - base_w;
      tests_run++;
      if (got_n != int'(n) || (idx_q.size() - base_i) != int'(n)) begin
         tests_failed++;
         $display("FAIL %s_word_count: got %0d writes %0d reads, want %0d", tag,
                  got_n, idx_q.size() - base_i, n);
      end
      for (int i = 0; i < int'(n); i++) begin
         if (base_w + i >= wr_addr_q.size() || base_i + i >= idx_q.size()) break;
         si = s + 8'(i);
         ea = d + ADDR_W'(i);
         tests_run++;
         if (wr_addr_q[base_w+i] !== ea || wr_data_q[base_w+i] !== dev_buf[si] ||
             idx_q[base_i+i] !== {1'b1, si}) begin
            tests_failed++;
            $display("FAIL %s_word%0d: got addr %h data %h idx %h, want addr %h data %h idx %h",
                     tag, i, wr_addr_q[base_w+i], wr_data_q[base_w+i], idx_q[base_i+i],
                     ea, dev_buf[si], {1'b1, si});
         end
      end

      tests_run++;
      if ((irq_cnt - base_irq) != 1 || irq_wide != base_wide) begin
         tests_failed++;
         $display("FAIL %s_irq: got %0d pulses %0d wide, want 1 pulse 0 wide", tag,
                  irq_cnt - base_irq, irq_wide - base_wide);
      end

      read_reg(2'd3, rd);
      tests_run++;
      if (rd !== 32'h2) begin
         tests_failed++;
         $display("FAIL %s_status: got %h want %h", tag, rd, 32'h2);
      end

`ifdef DMA_AUTOINIT_EN
      exp_src = s; exp_dst = d; exp_cnt = n;
`else
      exp_src = s + 8'(n); exp_dst = d + ADDR_W'(n); exp_cnt = '0;
`endif
      read_reg(2'd0, rd);
      tests_run++;
      if (rd !== {24'd0, exp_src}) begin
         tests_failed++;
         $display("FAIL %s_src_final: got %h want %h", tag, rd, exp_src);
      end
      read_reg(2'd1, rd);
      tests_run++;
      if (rd !== 32'(exp_dst)) begin
         tests_failed++;
         $display("FAIL %s_dst_final: got %h want %h", tag, rd, exp_dst);
      end
      read_reg(2'd2, rd);
      tests_run++;
      if (rd !== 32'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL %s_cnt_final: got %h want %h", tag, rd, exp_cnt);
      end
   endtask

   // Holds dreq for a while and expects the channel to stay completely quiet.
   task automatic expect_ignored(input string tag);
      int b_h, b_w, b_irq;
      b_h = hreq_cycles; b_w = wr_addr_q.size(); b_irq = irq_cnt;
      dreq = 1'b1;
      repeat (20) @(negedge clk);
      dreq = 1'b0;
      @(negedge clk);
      tests_run++;
      if (hreq_cycles != b_h || wr_addr_q.size() != b_w || irq_cnt != b_irq) begin
         tests_failed++;
         $display("FAIL %s: got hold %0d writes %0d irq %0d, want 0 0 0", tag,
                  hreq_cycles - b_h, wr_addr_q.size() - b_w, irq_cnt - b_irq);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      tests_run++;
      if ({dack, hold_req, io_index, io_write, mem_addr, mem_wdata, mem_we, busy, done_irq} !== '0) begin
         tests_failed++;
         $display("FAIL %s: got dack %b hreq %b idx %h we %b addr %h data %h busy %b irq %b, want all 0",
                  tag, dack, hold_req, io_index, mem_we, mem_addr, mem_wdata, busy, done_irq);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), rd);
         tests_run++;
         if (rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_reg%0d: got %h want 0", a, rd);
         end
      end
   endtask

   task automatic test_basic();
      program_regs(8'h00, 13'h100, 9'd4);
      run_block(8'h00, 13'h100, 9'd4, "basic");
   endtask

   task automatic test_zero_count();
      cfg_write(2'd2, 32'd0);
      expect_ignored("zero_count");
   endtask

   task automatic test_pause();
      int b_w, b_p;
      bit seen;
      program_regs(8'h10, 13'h200, 9'd6);
      b_w = wr_addr_q.size();
      b_p = pause_cycles;
      fork
         run_block(8'h10, 13'h200, 9'd6, "pause");
         begin
            seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
               @(posedge clk);
               if (wr_addr_q.size() >= b_w + 3) begin seen = 1'b1; break; end
            end
            force_low = 1'b1;
            repeat (5) @(posedge clk);
            force_low = 1'b0;
            tests_run++;
            if (!seen) begin
               tests_failed++;
               $display("FAIL pause_word2_timeout: got %0d writes, want 3", wr_addr_q.size() - b_w);
            end
         end
      join
      tests_run++;
      if (pause_cycles - b_p < 5) begin
         tests_failed++;
         $display("FAIL pause_req_cycles: got %0d, want at least 5", pause_cycles - b_p);
      end
   endtask

   task automatic test_wrap();
      program_regs(8'hFE, 13'h1FFF, 9'd3);
      run_block(8'hFE, 13'h1FFF, 9'd3, "wrap");
   endtask

   task automatic test_reset_mid();
      int k;
      logic [31:0] rd;
      program_regs(8'h00, 13'h300, 9'd4);
      dreq = 1'b1;
      k = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_we) k++;
         if (k == 2) break;
      end
      tests_run++;
      if (k != 2) begin
         tests_failed++;
         $display("FAIL reset_mid_reach: got %0d writes, want 2", k);
      end
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_mid_outputs");
      reset = 1'b0;
      dreq  = 1'b0;
      read_reg(2'd2, rd);
      tests_run++;
      if (rd !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_cnt: got %h want 0", rd);
      end
      program_regs(8'h05, 13'h400, 9'd3);
      run_block(8'h05, 13'h400, 9'd3, "after_reset");
   endtask

   task automatic test_autoinit();
      program_regs(8'h20, 13'h500, 9'd2);
      run_block(8'h20, 13'h500, 9'd2, "autoinit_1");
`ifdef DMA_AUTOINIT_EN
      run_block(8'h20, 13'h500, 9'd2, "autoinit_2");
`else
      expect_ignored("no_autoinit_2");
`endif
   endtask

   task automatic test_random();
      logic [7:0]        s;
      logic [ADDR_W-1:0] d;
      logic [CNT_W-1:0]  n;
      rand_stall = 1'b1;
      for (int it = 0; it < 6; it++) begin
         s = 8'($urandom);
         d = ADDR_W'($urandom);
         n = CNT_W'($urandom_range(1, 24));
         program_regs(s, d, n);
         run_block(s, d, n, "random");
      end
      rand_stall = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dev_buf[i] = $urandom;
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0; dreq = 1'b0;
      test_reset();
      test_basic();
      test_zero_count();
      test_pause();
      test_wrap();
      test_reset_mid();
      test_autoinit();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
